// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants and types for the SRAM-backed FIFO controller.
package sram_fifo_pkg;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 5;
    // SRAM words plus the two output-buffer slots.
    localparam int CAP    = DEPTH + 2;

    typedef logic [ADDR_W:0]   ptr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Producer/consumer handshake plus macro-side pins of the FIFO controller.
interface sram_fifo_ctrl_if;
    import sram_fifo_pkg::*;

    logic                flush;
    logic                enq_valid;
    logic                enq_ready;
    data_t               enq_bits;
    logic                deq_valid;
    logic                deq_ready;
    data_t               deq_bits;
    logic [CNT_W-1:0]    count;
    logic                sram_web;
    logic [ADDR_W-1:0]   sram_aa;
    data_t               sram_d;
    logic                sram_reb;
    logic [ADDR_W-1:0]   sram_ab;
    data_t               sram_q;

    modport slave (
        input  flush, enq_valid, enq_bits, deq_ready, sram_q,
        output enq_ready, deq_valid, deq_bits, count,
               sram_web, sram_aa, sram_d, sram_reb, sram_ab
    );

    modport master (
        output flush, enq_valid, enq_bits, deq_ready, sram_q,
        input  enq_ready, deq_valid, deq_bits, count,
               sram_web, sram_aa, sram_d, sram_reb, sram_ab
    );
endinterface

// File: rtl/sram_fifo_ctrl_obuf.sv
// Two-entry in-order output buffer that absorbs the macro's read latency.
module sram_fifo_obuf
    import sram_fifo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  data_t      din_i,
    output data_t      dout_o,
    output logic [1:0] cnt_o
);
    data_t      e0_q, e0_d, e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            e0_d  = '0;
            e1_d  = '0;
            cnt_d = '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = din_i;
                    else               e1_d = din_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                // Pop and push together: count holds, new word lands behind the survivor.
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = din_i;
                    end else begin
                        e0_d = e1_q;
                        e1_d = din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o = e0_q;
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller for an external two-port SRAM macro with 1-cycle read latency.
// Optional high-water-mark output enabled by defining SRAM_FIFO_HWM_EN.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
`ifdef SRAM_FIFO_HWM_EN
    output logic [CNT_W-1:0] hwm,
`endif
    sram_fifo_ctrl_if.slave  bus
);
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    ptr_t              sram_cnt_q, sram_cnt_d;
    cnt_t              count_q, count_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] ab_q, ab_d;
    logic [1:0]        ob_cnt;
    logic [1:0]        occ;
    data_t             ob_dout;
    logic              enq_fire, deq_fire, rd_issue;

    assign bus.enq_ready = (count_q < cnt_t'(CAP)) && !bus.flush;
    assign bus.deq_valid = (ob_cnt != 2'd0);
    assign bus.deq_bits  = ob_dout;
    assign bus.count     = count_q;

    assign enq_fire = bus.enq_valid && bus.enq_ready;
    assign deq_fire = bus.deq_valid && bus.deq_ready;

    // Slots already claimed downstream of the macro; a read may only go out if one will be free.
    assign occ      = ob_cnt + {1'b0, rd_pend_q};
    assign rd_issue = !bus.flush && (sram_cnt_q != '0) &&
                      ((occ < 2'd2) || ((occ == 2'd2) && deq_fire));

    assign bus.sram_web = !enq_fire;
    assign bus.sram_aa  = wr_ptr_q[ADDR_W-1:0];
    assign bus.sram_d   = bus.enq_bits;
    assign bus.sram_reb = !rd_issue;
    assign bus.sram_ab  = rd_issue ? rd_ptr_q[ADDR_W-1:0] : ab_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sram_cnt_d = sram_cnt_q;
        count_d    = count_q;
        rd_pend_d  = rd_pend_q;
        ab_d       = ab_q;
        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            sram_cnt_d = '0;
            count_d    = '0;
            rd_pend_d  = 1'b0;
        end else begin
            if (enq_fire) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (rd_issue) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
                ab_d     = rd_ptr_q[ADDR_W-1:0];
            end
            sram_cnt_d = sram_cnt_q + ptr_t'(enq_fire) - ptr_t'(rd_issue);
            count_d    = count_q + cnt_t'(enq_fire) - cnt_t'(deq_fire);
            rd_pend_d  = rd_issue;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_cnt_q <= '0;
            count_q    <= '0;
            rd_pend_q  <= 1'b0;
            ab_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            count_q    <= count_d;
            rd_pend_q  <= rd_pend_d;
            ab_q       <= ab_d;
        end
    end

    // Macro data is only meaningful the cycle after a read was issued.
    sram_fifo_obuf u_obuf (
        .clock   (clock),
        .reset   (reset),
        .flush_i (bus.flush),
        .push_i  (rd_pend_q && !bus.flush),
        .pop_i   (deq_fire && !bus.flush),
        .din_i   (bus.sram_q),
        .dout_o  (ob_dout),
        .cnt_o   (ob_cnt)
    );

`ifdef SRAM_FIFO_HWM_EN
    cnt_t hwm_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                hwm_q <= '0;
        else if (count_q > hwm_q) hwm_q <= count_q;
    end
    assign hwm = hwm_q;
`endif

    a_ptr_consistent: assert property (@(posedge clock) disable iff (reset)
        ptr_t'(wr_ptr_q - rd_ptr_q) == sram_cnt_q);
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 16x128 two-port macro.
module tb_sram_fifo_ctrl;
    import sram_fifo_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nvec  = 0;
    int   nerr  = 0;

    sram_fifo_ctrl_if bus ();
`ifdef SRAM_FIFO_HWM_EN
    logic [CNT_W-1:0] hwm;
`endif

    sram_fifo_ctrl dut (
        .clock (clock),
        .reset (reset),
`ifdef SRAM_FIFO_HWM_EN
        .hwm   (hwm),
`endif
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Macro model: registered read, garbage on cycles without a read.
    data_t mem [DEPTH];
    always @(posedge clock) begin
        if (!bus.sram_web) mem[bus.sram_aa] <= bus.sram_d;
        if (!bus.sram_reb) bus.sram_q <= mem[bus.sram_ab];
        else               bus.sram_q <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.flush     = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_bits  = '0;
        bus.deq_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        #1;
        nvec++; if (bus.count !== cnt_t'(0)) begin nerr++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        nvec++; if (bus.deq_valid !== 1'b0) begin nerr++; $display("FAIL reset_deq_valid: got %b want 0", bus.deq_valid); end
        nvec++; if (bus.sram_web !== 1'b1 || bus.sram_reb !== 1'b1) begin nerr++; $display("FAIL reset_enables: got web=%b reb=%b want 1 1", bus.sram_web, bus.sram_reb); end
        nvec++; if (bus.sram_aa !== 4'd0 || bus.sram_ab !== 4'd0) begin nerr++; $display("FAIL reset_addr: got aa=%0d ab=%0d want 0 0", bus.sram_aa, bus.sram_ab); end
        nvec++; if (bus.deq_bits !== data_t'(0)) begin nerr++; $display("FAIL reset_deq_bits: got %h want 0", bus.deq_bits); end
        nvec++; if (bus.enq_ready !== 1'b1) begin nerr++; $display("FAIL reset_enq_ready: got %b want 1", bus.enq_ready); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        data_t pat;
        pat = {16{8'hA5}};
        tick();
        bus.deq_ready = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_bits  = pat;
        #1;
        nvec++; if (bus.sram_web !== 1'b0 || bus.sram_aa !== 4'd0 || bus.sram_d !== pat) begin nerr++; $display("FAIL single_write: got web=%b aa=%0d d=%h want 0 0 %h", bus.sram_web, bus.sram_aa, bus.sram_d, pat); end
        tick();
        bus.enq_valid = 1'b0;
        #1;
        nvec++; if (bus.sram_reb !== 1'b0 || bus.sram_ab !== 4'd0) begin nerr++; $display("FAIL single_read: got reb=%b ab=%0d want 0 0", bus.sram_reb, bus.sram_ab); end
        nvec++; if (bus.count !== cnt_t'(1)) begin nerr++; $display("FAIL single_count1: got %0d want 1", bus.count); end
        tick(); #1;
        nvec++; if (bus.deq_valid !== 1'b0) begin nerr++; $display("FAIL single_early_valid: got %b want 0", bus.deq_valid); end
        tick(); #1;
        nvec++; if (bus.deq_valid !== 1'b1 || bus.deq_bits !== pat) begin nerr++; $display("FAIL single_deq: got v=%b d=%h want 1 %h", bus.deq_valid, bus.deq_bits, pat); end
        tick(); #1;
        nvec++; if (bus.count !== cnt_t'(0) || bus.deq_valid !== 1'b0) begin nerr++; $display("FAIL single_empty: got count=%0d v=%b want 0 0", bus.count, bus.deq_valid); end
        bus.deq_ready = 1'b0;
    endtask

    task automatic test_fill();
        int acc = 0;
        int first_ref = -1;
        int idx;
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.enq_valid = 1'b1;
            bus.enq_bits  = data_t'(i);
            #1;
            if (bus.enq_ready) acc++;
            else if (first_ref < 0) first_ref = i;
        end
        tick();
        bus.enq_valid = 1'b0;
        #1;
        nvec++; if (acc != 18 || first_ref != 18) begin nerr++; $display("FAIL fill_accepts: got %0d first_refused=%0d want 18 18", acc, first_ref); end
        nvec++; if (bus.count !== cnt_t'(18) || bus.enq_ready !== 1'b0) begin nerr++; $display("FAIL fill_full: got count=%0d rdy=%b want 18 0", bus.count, bus.enq_ready); end
        bus.deq_ready = 1'b1;
        #1;
        nvec++; if (bus.deq_valid !== 1'b1 || bus.deq_bits !== data_t'(0)) begin nerr++; $display("FAIL fill_head: got v=%b d=%h want 1 0", bus.deq_valid, bus.deq_bits); end
        nvec++; if (bus.enq_ready !== 1'b0) begin nerr++; $display("FAIL fill_no_comb_reopen: got %b want 0", bus.enq_ready); end
        idx = 1;
        tick(); #1;
        nvec++; if (bus.enq_ready !== 1'b1) begin nerr++; $display("FAIL fill_reopen: got %b want 1", bus.enq_ready); end
        for (int c = 0; c < 60 && idx < 18; c++) begin
            if (bus.deq_valid) begin
                nvec++; if (bus.deq_bits !== data_t'(idx)) begin nerr++; $display("FAIL fill_order: got %h want %h", bus.deq_bits, data_t'(idx)); end
                idx++;
            end
            tick(); #1;
        end
        nvec++; if (idx != 18 || bus.count !== cnt_t'(0)) begin nerr++; $display("FAIL fill_drain: got %0d words count=%0d want 18 0", idx, bus.count); end
        bus.deq_ready = 1'b0;
    endtask

    task automatic test_stream();
        int sent = 0, rcvd = 0, gaps = 0, first_c = -1;
        bus.deq_ready = 1'b1;
        for (int c = 0; c < 100 && rcvd < 40; c++) begin
            tick();
            bus.enq_valid = (sent < 40);
            bus.enq_bits  = data_t'(256 + sent);
            #1;
            if (bus.enq_valid && bus.enq_ready) sent++;
            if (bus.deq_valid) begin
                if (first_c < 0) first_c = c;
                nvec++; if (bus.deq_bits !== data_t'(256 + rcvd)) begin nerr++; $display("FAIL stream_order: got %h want %h", bus.deq_bits, data_t'(256 + rcvd)); end
                rcvd++;
            end else if (first_c >= 0) gaps++;
        end
        bus.enq_valid = 1'b0;
        nvec++; if (rcvd != 40 || gaps != 0) begin nerr++; $display("FAIL stream_rate: got rcvd=%0d gaps=%0d want 40 0", rcvd, gaps); end
        nvec++; if (first_c != 3) begin nerr++; $display("FAIL stream_latency: got %0d want 3", first_c); end
        tick();
        bus.deq_ready = 1'b0;
        #1;
        nvec++; if (bus.count !== cnt_t'(0)) begin nerr++; $display("FAIL stream_empty: got %0d want 0", bus.count); end
    endtask

    task automatic test_random();
        data_t q[$];
        data_t exp;
        for (int c = 0; c < 1000; c++) begin
            tick();
            bus.enq_valid = 1'($urandom_range(0, 1));
            bus.enq_bits  = {$urandom, $urandom, $urandom, $urandom};
            bus.deq_ready = 1'($urandom_range(0, 1));
            #1;
            nvec++; if (int'(bus.count) != q.size() || bus.count > cnt_t'(18)) begin nerr++; $display("FAIL rand_count: got %0d want %0d", bus.count, q.size()); end
            nvec++; if (bus.enq_ready !== (q.size() < 18)) begin nerr++; $display("FAIL rand_enq_ready: got %b at size %0d", bus.enq_ready, q.size()); end
            if (bus.deq_valid && bus.deq_ready) begin
                nvec++;
                if (q.size() == 0) begin nerr++; $display("FAIL rand_underflow: got deq with empty model, want none"); end
                else begin
                    exp = q.pop_front();
                    if (bus.deq_bits !== exp) begin nerr++; $display("FAIL rand_data: got %h want %h", bus.deq_bits, exp); end
                end
            end
            if (bus.enq_valid && bus.enq_ready) q.push_back(bus.enq_bits);
        end
        tick();
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b1;
        #1;
        for (int c = 0; c < 60 && q.size() > 0; c++) begin
            if (bus.deq_valid) begin
                exp = q.pop_front();
                nvec++; if (bus.deq_bits !== exp) begin nerr++; $display("FAIL rand_drain: got %h want %h", bus.deq_bits, exp); end
            end
            tick(); #1;
        end
        nvec++; if (q.size() != 0 || bus.count !== cnt_t'(0)) begin nerr++; $display("FAIL rand_drain_done: got left=%0d count=%0d want 0 0", q.size(), bus.count); end
        bus.deq_ready = 1'b0;
    endtask

    task automatic test_flush();
        int got = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            bus.enq_valid = 1'b1;
            bus.enq_bits  = data_t'(512 + i);
        end
        tick();
        bus.enq_valid = 1'b0;
        tick(); tick(); tick();
        bus.deq_ready = 1'b1;
        #1;
        nvec++; if (bus.count !== cnt_t'(11) || bus.sram_reb !== 1'b0) begin nerr++; $display("FAIL flush_setup: got count=%0d reb=%b want 11 0", bus.count, bus.sram_reb); end
        tick();
        bus.deq_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_bits  = data_t'(32'hDEAD);
        #1;
        nvec++; if (bus.count !== cnt_t'(10)) begin nerr++; $display("FAIL flush_pre_count: got %0d want 10", bus.count); end
        nvec++; if (bus.enq_ready !== 1'b0 || bus.sram_web !== 1'b1 || bus.sram_reb !== 1'b1) begin nerr++; $display("FAIL flush_block: got rdy=%b web=%b reb=%b want 0 1 1", bus.enq_ready, bus.sram_web, bus.sram_reb); end
        tick();
        bus.flush     = 1'b0;
        bus.enq_valid = 1'b0;
        #1;
        nvec++; if (bus.count !== cnt_t'(0) || bus.deq_valid !== 1'b0) begin nerr++; $display("FAIL flush_clear: got count=%0d v=%b want 0 0", bus.count, bus.deq_valid); end
        tick();
        bus.enq_valid = 1'b1;
        bus.enq_bits  = data_t'(16'h1234);
        tick();
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b1;
        #1;
        for (int c = 0; c < 10 && got == 0; c++) begin
            if (bus.deq_valid) begin
                got = 1;
                nvec++; if (bus.deq_bits !== data_t'(16'h1234)) begin nerr++; $display("FAIL flush_first: got %h want 1234", bus.deq_bits); end
            end
            tick(); #1;
        end
        nvec++; if (got != 1 || bus.count !== cnt_t'(0)) begin nerr++; $display("FAIL flush_deliver: got seen=%0d count=%0d want 1 0", got, bus.count); end
        bus.deq_ready = 1'b0;
    endtask

`ifdef SRAM_FIFO_HWM_EN
    task automatic test_hwm();
        reset = 1'b1;
        idle();
        tick(); #1;
        nvec++; if (hwm !== cnt_t'(0)) begin nerr++; $display("FAIL hwm_reset: got %0d want 0", hwm); end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            bus.enq_valid = 1'b1;
            bus.enq_bits  = data_t'(i);
        end
        tick();
        bus.enq_valid = 1'b0;
        tick(); #1;
        nvec++; if (bus.count !== cnt_t'(12) || hwm !== cnt_t'(12)) begin nerr++; $display("FAIL hwm_fill: got count=%0d hwm=%0d want 12 12", bus.count, hwm); end
        bus.deq_ready = 1'b1;
        for (int c = 0; c < 30; c++) tick();
        bus.deq_ready = 1'b0;
        #1;
        nvec++; if (bus.count !== cnt_t'(0) || hwm !== cnt_t'(12)) begin nerr++; $display("FAIL hwm_drain: got count=%0d hwm=%0d want 0 12", bus.count, hwm); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick(); #1;
        nvec++; if (hwm !== cnt_t'(12)) begin nerr++; $display("FAIL hwm_flush: got %0d want 12", hwm); end
        reset = 1'b1;
        #2;
        nvec++; if (hwm !== cnt_t'(0)) begin nerr++; $display("FAIL hwm_rereset: got %0d want 0", hwm); end
        reset = 1'b0;
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_flush();
`ifdef SRAM_FIFO_HWM_EN
        test_hwm();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Valid/ready FIFO controller that drives an external 16x128 two-port SRAM macro and consumes its registered read data.
- The macro has active-low write and read enables and 1-cycle read latency. Its read data is undefined when it is not read.
- The controller hides that latency behind a 2-entry output buffer. Total capacity is DEPTH+2, and it sustains 1 enq + 1 deq per cycle.
- It sits between a producer pipeline stage and the macro instance in the same wrapper level.

Parameters:
- DATA_W, 128: payload width; must equal the macro bit width.
- DEPTH, 16: macro word count; power of two.
- ADDR_W, 4: log2(DEPTH).
- CNT_W, 5: width of the occupancy count; holds 0..DEPTH+2.

Ports:
- clock  in  1  single clock for the block and the macro (CLKW/CLKR both tied to it).
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous clear of all contents.
- enq_valid  in  1  producer data valid.
- enq_ready  out  1  space available.
- enq_bits  in  DATA_W  producer payload.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  consumer accepts.
- deq_bits  out  DATA_W  head payload.
- count  out  CNT_W  total entries held (SRAM + in-flight read + output buffer).
- sram_web  out  1  macro write enable, active-low.
- sram_aa  out  ADDR_W  macro write address.
- sram_d  out  DATA_W  macro write data.
- sram_reb  out  1  macro read enable, active-low.
- sram_ab  out  ADDR_W  macro read address.
- sram_q  in  DATA_W  macro read data, registered by the macro.

Behaviour:
- Reset (async, active-high):
  - wr_ptr = 0, rd_ptr = 0 (each ADDR_W+1 bits, MSB is the wrap bit).
  - sram_cnt = 0, rd_pend = 0, ob_cnt = 0, count = 0.
  - deq_valid = 0, sram_web = 1, sram_reb = 1, sram_aa = 0, sram_ab = 0.
  - deq_bits = 0 and the output buffer is zeroed.
- enq_ready = (count < DEPTH+2) and !flush; combinational from registered state only.
- Enqueue fire (enq_valid & enq_ready) in cycle T:
  - sram_web = 0, sram_aa = wr_ptr[ADDR_W-1:0], sram_d = enq_bits, all combinational in T.
  - wr_ptr increments modulo 2*DEPTH; sram_cnt increments at the end of T.
- Read issue in cycle T when (sram_cnt > 0) and (ob_cnt + rd_pend < 2), or ob_cnt + rd_pend == 2 with a deq fire in T:
  - sram_reb = 0, sram_ab = rd_ptr[ADDR_W-1:0].
  - rd_ptr increments, sram_cnt decrements, and rd_pend is set for T+1.
- Otherwise sram_reb = 1 and sram_ab holds its last value.
- Read capture: in cycle T+1, sram_q is pushed into the output buffer (2-entry, in order) at the end of T+1, and rd_pend clears unless a new read was issued in T+1.
- sram_q is never sampled unless rd_pend = 1.
- Simultaneous enq and read issue: a read never targets an address written in the same cycle. sram_cnt counts only entries written in prior cycles, so there is no same-address collision.
- Enq-to-deq latency is 3 cycles on an empty FIFO: write T, read T+1, capture T+2, deq_valid in T+3.
- Output buffer:
  - deq_valid = (ob_cnt > 0); deq_bits is entry 0.
  - deq fire shifts entry 1 to entry 0.
  - Push and pop in the same cycle keep order and ob_cnt is unchanged.
- count = sram_cnt + rd_pend + ob_cnt, registered. It updates +1 on enq fire, -1 on deq fire, and is unchanged when both happen.
- Full: count == DEPTH+2, so enq_ready = 0. A same-cycle deq does NOT reopen enq_ready; there is no combinational deq-to-enq path.
- Empty: count == 0, so deq_valid = 0 and sram_reb = 1.
- Wrap-around:
  - Pointers roll from 2*DEPTH-1 to 0.
  - Full/empty of the SRAM part is taken from sram_cnt, not from pointer compare; pointer compare is used only for assertion.
- Flush:
  - Next cycle: pointers, sram_cnt, rd_pend, ob_cnt and count are 0, and deq_valid = 0.
  - Any in-flight read data is discarded.
  - enq and read issue are blocked during the flush cycle; the macro contents are left stale.
- Reset mid-operation: all state clears immediately. Any macro read issued before reset is ignored because rd_pend = 0.

Optional Feature:
- Macro: SRAM_FIFO_HWM_EN.
- With the macro defined:
  - Adds output hwm [CNT_W-1:0], a high-water mark of count.
  - hwm updates to count when count > hwm; a flush does not clear it.
  - Reset clears it to 0.
- Without the macro: the port and its register are absent, with no other change.

Decomposition:
- Package sram_fifo_pkg:
  - constants DATA_W = 128, DEPTH = 16, ADDR_W = 4, CNT_W = 5.
  - typedef ptr_t (ADDR_W+1 bits) and typedef data_t.
- One natural sub-module: sram_fifo_obuf, the 2-entry in-order output buffer with push/pop/flush and ob_cnt.
- The macro is instantiated by the parent wrapper, not inside this block.

Test Plan:
- Single enq of 0xA5..A5 at cycle 0 after reset, with deq_ready = 1:
  - sram_web low in cycle 0; sram_reb low with sram_ab = 0 in cycle 1.
  - deq_valid in cycle 3 with deq_bits = 0xA5..A5; count returns to 0 in cycle 4.
- Fill with deq_ready = 0, writing values 0..19:
  - enq_ready drops after 18 accepts and count = 18.
  - Then draining yields 0..17 in order, and enq_ready rises the cycle after the first deq.
- Continuous enq and deq of 40 words: after the 3-cycle fill, deq fires every cycle, and data crosses the pointer wrap with order preserved.
- Random 50% enq/deq stall for 1000 cycles: scoreboard matches, and count never exceeds 18.
- Flush with count = 10 and a read in flight: the next cycle count = 0 and deq_valid = 0; a subsequent enq of 0x1234 is delivered first.
- With SRAM_FIFO_HWM_EN defined: fill to 12, drain, then flush; hwm = 12 throughout, and it becomes 0 only after reset.
